// File: rtl/random_spawn_sampler.sv
// random_spawn_sampler: turns LFSR words into bounded spawn coordinates by rejection sampling with a keep-out box
module random_spawn_sampler #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int X_LO      = 16,
    parameter int X_HI      = 783,
    parameter int Y_LO      = 16,
    parameter int Y_HI      = 583,
    parameter int MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    random_i,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           ko_en,
    input  logic [X_W-1:0] ko_x0,
    input  logic [X_W-1:0] ko_x1,
    input  logic [Y_W-1:0] ko_y0,
    input  logic [Y_W-1:0] ko_y1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           forced
);
    localparam int SX  = X_HI - X_LO;
    localparam int SY  = Y_HI - Y_LO;
    localparam int MX  = (1 << $clog2(SX + 1)) - 1;
    localparam int MY  = (1 << $clog2(SY + 1)) - 1;
    localparam int T_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [T_W-1:0] tries_q, tries_d;
    logic           ko_en_q, ko_en_d;
    logic [X_W-1:0] ko_x0_q, ko_x0_d, ko_x1_q, ko_x1_d;
    logic [Y_W-1:0] ko_y0_q, ko_y0_d, ko_y1_q, ko_y1_d;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d;
    logic           forced_q, forced_d;
    logic [X_W-1:0] cx, ax, fx;
    logic [Y_W-1:0] cy, ay, fy;
    logic           in_ko, ok;
    logic           unused_rand;

    assign unused_rand = ^random_i;
    assign req_ready   = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign forced      = forced_q;

    // Candidate evaluation and next-state/register update logic
    always_comb begin
        cx       = random_i[X_W-1:0] & X_W'(MX);
        cy       = random_i[16+:Y_W] & Y_W'(MY);
        ax       = X_W'(X_LO) + cx;
        ay       = Y_W'(Y_LO) + cy;
        fx       = (cx > X_W'(SX)) ? cx - X_W'(SX + 1) : cx;
        fy       = (cy > Y_W'(SY)) ? cy - Y_W'(SY + 1) : cy;
        in_ko    = ko_en_q && ax >= ko_x0_q && ax <= ko_x1_q && ay >= ko_y0_q && ay <= ko_y1_q;
        ok       = cx <= X_W'(SX) && cy <= Y_W'(SY) && !in_ko;
        state_d  = state_q;
        tries_d  = tries_q;
        ko_en_d  = ko_en_q;
        ko_x0_d  = ko_x0_q;
        ko_x1_d  = ko_x1_q;
        ko_y0_d  = ko_y0_q;
        ko_y1_d  = ko_y1_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        forced_d = forced_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = SAMPLE;
                tries_d = '0;
                ko_en_d = ko_en;
                ko_x0_d = ko_x0;
                ko_x1_d = ko_x1;
                ko_y0_d = ko_y0;
                ko_y1_d = ko_y1;
            end
            SAMPLE: if (ok) begin
                state_d  = HOLD;
                pos_x_d  = ax;
                pos_y_d  = ay;
                forced_d = 1'b0;
                tries_d  = '0;
            end else if (tries_q == T_W'(MAX_TRIES - 1)) begin
                state_d  = HOLD;
                pos_x_d  = X_W'(X_LO) + fx;
                pos_y_d  = Y_W'(Y_LO) + fy;
                forced_d = 1'b1;
                tries_d  = '0;
            end else begin
                tries_d = tries_q + 1'b1;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tries_q  <= '0;
            ko_en_q  <= 1'b0;
            ko_x0_q  <= '0;
            ko_x1_q  <= '0;
            ko_y0_q  <= '0;
            ko_y1_q  <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            ko_en_q  <= ko_en_d;
            ko_x0_q  <= ko_x0_d;
            ko_x1_q  <= ko_x1_d;
            ko_y0_q  <= ko_y0_d;
            ko_y1_q  <= ko_y1_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            forced_q <= forced_d;
        end
    end
endmodule

// File: tb/tb_random_spawn_sampler.sv
// tb_random_spawn_sampler: directed vector table plus handshake-stall and reset sequences
module tb_random_spawn_sampler;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] random_i;
    logic        req_valid, req_ready;
    logic        ko_en;
    logic [9:0]  ko_x0, ko_x1, ko_y0, ko_y1;
    logic        out_valid, out_ready;
    logic [9:0]  pos_x, pos_y;
    logic        forced;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ko_en;
        logic [9:0]  x0, x1, y0, y1;
        logic [31:0] r0;
        int          n0;
        logic [31:0] r1;
        int          lat;
        int          ex, ey;
        logic        ef;
    } vec_t;

    vec_t vecs[11];

    random_spawn_sampler dut (
        .clk(clk), .rst(rst), .random_i(random_i), .req_valid(req_valid), .req_ready(req_ready),
        .ko_en(ko_en), .ko_x0(ko_x0), .ko_x1(ko_x1), .ko_y0(ko_y0), .ko_y1(ko_y1),
        .out_valid(out_valid), .out_ready(out_ready), .pos_x(pos_x), .pos_y(pos_y), .forced(forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int k;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1;
        ko_en = v.ko_en; ko_x0 = v.x0; ko_x1 = v.x1; ko_y0 = v.y0; ko_y1 = v.y1;
        random_i = v.r0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ko_en = ~v.ko_en; ko_x0 = 10'd0; ko_x1 = 10'd1023; ko_y0 = 10'd1023; ko_y1 = 10'd0;
        chk($sformatf("v%0d sample_req_ready", idx), int'(req_ready), 0);
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            random_i = (i <= v.n0) ? v.r0 : v.r1;
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                k = i;
            end
        end
        chk($sformatf("v%0d out_valid_seen", idx), int'(seen), 1);
        chk($sformatf("v%0d latency", idx), k + 1, v.lat);
        chk($sformatf("v%0d pos_x", idx), int'(pos_x), v.ex);
        chk($sformatf("v%0d pos_y", idx), int'(pos_y), v.ey);
        chk($sformatf("v%0d forced", idx), int'(forced), int'(v.ef));
        chk($sformatf("v%0d hold_req_ready", idx), int'(req_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d idle_out_valid", idx), int'(out_valid), 0);
        chk($sformatf("v%0d idle_req_ready", idx), int'(req_ready), 1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h0064_00C8, 99, 32'h0, 2, 216, 116, 1'b0};
        vecs[1]  = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h0000_03FF, 2,  32'h0, 4, 16,  16,  1'b0};
        vecs[2]  = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h03FF_03FF, 99, 32'h0, 9, 271, 471, 1'b1};
        vecs[3]  = '{1'b1, 10'd0,   10'd100,  10'd0,   10'd100,  32'h0000_0000, 1,  32'h0064_00C8, 3, 216, 116, 1'b0};
        vecs[4]  = '{1'b1, 10'd200, 10'd100,  10'd0,   10'd1000, 32'h0000_0000, 99, 32'h0, 2, 16,  16,  1'b0};
        vecs[5]  = '{1'b0, 10'd0,   10'd1023, 10'd0,   10'd1023, 32'h0000_0000, 99, 32'h0, 2, 16,  16,  1'b0};
        vecs[6]  = '{1'b1, 10'd216, 10'd216,  10'd116, 10'd116,  32'h0064_00C8, 1,  32'h0, 3, 16,  16,  1'b0};
        vecs[7]  = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h0237_02FF, 99, 32'h0, 2, 783, 583, 1'b0};
        vecs[8]  = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h0000_0300, 99, 32'h0, 9, 16,  16,  1'b1};
        vecs[9]  = '{1'b1, 10'd0,   10'd1023, 10'd0,   10'd1023, 32'h0000_0000, 99, 32'h0, 9, 16,  16,  1'b1};
        vecs[10] = '{1'b0, 10'd0,   10'd0,    10'd0,   10'd0,    32'h0238_0005, 99, 32'h0, 9, 21,  16,  1'b1};

        rst = 1'b1; random_i = '0; req_valid = 1'b0; out_ready = 1'b0;
        ko_en = 1'b0; ko_x0 = '0; ko_x1 = '0; ko_y0 = '0; ko_y1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", int'(req_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset pos_x", int'(pos_x), 0);
        chk("reset pos_y", int'(pos_y), 0);
        chk("reset forced", int'(forced), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run(i, vecs[i]);

        // HOLD stall: result stays put while consumer is not ready
        @(negedge clk);
        req_valid = 1'b1; ko_en = 1'b0; random_i = 32'h0064_00C8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall out_valid", int'(out_valid), 1);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            random_i = 32'h0000_0000 + i;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("stall%0d req_ready", i), int'(req_ready), 0);
            chk($sformatf("stall%0d pos_x", i), int'(pos_x), 216);
            chk($sformatf("stall%0d pos_y", i), int'(pos_y), 116);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall release out_valid", int'(out_valid), 0);
        chk("stall release req_ready", int'(req_ready), 1);

        // Reset during SAMPLE drops the in-flight request
        @(negedge clk);
        req_valid = 1'b1; random_i = 32'h03FF_03FF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sample out_valid", int'(out_valid), 0);
        chk("rst_sample req_ready", int'(req_ready), 1);
        chk("rst_sample pos_x", int'(pos_x), 0);
        chk("rst_sample pos_y", int'(pos_y), 0);
        chk("rst_sample forced", int'(forced), 0);
        random_i = 32'h0000_0000;
        begin
            int stale = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk("rst_sample stale outputs", stale, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
